// File: rtl/uart_frame_receiver.sv
// uart_frame_receiver
//   Collects the fixed 8-byte command frame from the UART byte stream and
//   presents it as opcode / address / data behind a valid/ready handshake.
//   A partial frame is thrown away after an idle gap of TIMEOUT_BYTES
//   byte-times so the link resynchronises by itself.
//
// Ports
//   i_clock        system clock, rising edge
//   i_n_reset      asynchronous active-low reset
//   i_rx_done      one-cycle "byte available" pulse from the UART receiver
//   i_rx_data      received byte, valid with i_rx_done
//   i_frame_ready  consumer takes the presented frame
//   o_frame_valid  a frame is held on the outputs
//   o_opcode       frame bytes 0-1 (big-endian)
//   o_addr         frame bytes 2-3 (big-endian)
//   o_data         frame bytes 4-7 (big-endian)
//   o_busy         a partial frame is being collected
//   o_timeout      one-cycle pulse: partial frame discarded
//   o_overrun      one-cycle pulse: completed frame dropped, output occupied
module uart_frame_receiver #(
  parameter int UART_HZ       = 50000000,
  parameter int BAUDRATE      = 115200,
  parameter int TIMEOUT_BYTES = 2
) (
  input  logic        i_clock,
  input  logic        i_n_reset,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  input  logic        i_frame_ready,
  output logic        o_frame_valid,
  output logic [15:0] o_opcode,
  output logic [15:0] o_addr,
  output logic [31:0] o_data,
  output logic        o_busy,
  output logic        o_timeout,
  output logic        o_overrun
);

  localparam int BYTE_CYCLES    = (UART_HZ / BAUDRATE) * 10;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * BYTE_CYCLES;
  localparam int TW             = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Counter value seen on the edge where the idle gap expires.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]    state;
  logic [2:0]    count;
  logic [TW-1:0] to_cnt;
  logic [55:0]   sr;
  logic [63:0]   frame_word;
  logic          slot_free;

  // Seven bytes already shifted in plus the byte arriving now.
  assign frame_word = {sr, i_rx_data};

  // The slot can take a new frame if empty or being emptied this cycle.
  assign slot_free  = !o_frame_valid || i_frame_ready;

  assign o_busy     = (state == COLLECT);

  always_ff @(posedge i_clock or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state         <= IDLE;
      count         <= 3'd0;
      to_cnt        <= '0;
      sr            <= '0;
      o_frame_valid <= 1'b0;
      o_opcode      <= '0;
      o_addr        <= '0;
      o_data        <= '0;
      o_timeout     <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;

      // Consumer handshake; a frame completing below may re-set valid.
      if (o_frame_valid && i_frame_ready)
        o_frame_valid <= 1'b0;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (i_rx_done) begin
            sr    <= {sr[47:0], i_rx_data};
            count <= 3'd1;
            state <= COLLECT;
          end
        end

        COLLECT: begin
          if (i_rx_done) begin
            // A byte always beats an expiring gap.
            sr     <= {sr[47:0], i_rx_data};
            to_cnt <= '0;
            if (count == 3'd7) begin
              count <= 3'd0;
              state <= IDLE;
              if (slot_free) begin
                o_opcode      <= frame_word[63:48];
                o_addr        <= frame_word[47:32];
                o_data        <= frame_word[31:0];
                o_frame_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              count <= count + 3'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            o_timeout <= 1'b1;
            count     <= 3'd0;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          count  <= 3'd0;
          to_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
module tb_uart_frame_receiver;

  // Scaled-down link so every scenario fits a short run: 200-cycle bytes.
  localparam int UART_HZ  = 1000000;
  localparam int BAUDRATE = 50000;
  localparam int TO_BYTES = 2;
  localparam int BYTE_CYC = (UART_HZ / BAUDRATE) * 10;
  localparam int TO_CYC   = TO_BYTES * BYTE_CYC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        frame_ready = 1'b0;
  logic        o_frame_valid, o_busy, o_timeout, o_overrun;
  logic [15:0] o_opcode, o_addr;
  logic [31:0] o_data;

  uart_frame_receiver #(
    .UART_HZ(UART_HZ), .BAUDRATE(BAUDRATE), .TIMEOUT_BYTES(TO_BYTES)
  ) dut (
    .i_clock(clk), .i_n_reset(rst_n), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_frame_ready(frame_ready), .o_frame_valid(o_frame_valid),
    .o_opcode(o_opcode), .o_addr(o_addr), .o_data(o_data),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_to_seen = 0;
  int n_ovr_seen = 0;

  // Model: bytes of the frame in progress, cycles since the last byte,
  // and the frame currently offered to the consumer.
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_valid;
  logic [63:0] m_frame;
  bit          m_to, m_ovr;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_idle  = 0;
    m_valid = 0;
    m_frame = '0;
    m_to    = 0;
    m_ovr   = 0;
  endtask

  task automatic model_step(input bit done, input logic [7:0] b, input bit rdy);
    logic [63:0] f;
    m_to  = 0;
    m_ovr = 0;
    if (m_valid && rdy) m_valid = 0;
    if (done) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == 8) begin
        f = '0;
        foreach (m_q[i]) f = (f << 8) | 64'(m_q[i]);
        m_q.delete();
        if (!m_valid) begin
          m_frame = f;
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle == TO_CYC) begin
        m_to = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic compare();
    chk(o_frame_valid === m_valid, "valid", 64'(o_frame_valid), 64'(m_valid));
    if (m_valid)
      chk({o_opcode, o_addr, o_data} === m_frame, "frame", {o_opcode, o_addr, o_data}, m_frame);
    chk(o_busy === (m_q.size() != 0), "busy", 64'(o_busy), 64'(m_q.size() != 0));
    chk(o_timeout === m_to, "timeout", 64'(o_timeout), 64'(m_to));
    chk(o_overrun === m_ovr, "overrun", 64'(o_overrun), 64'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rx_done, rx_data, frame_ready);
    #1;
    compare();
    if (o_timeout === 1'b1) n_to_seen++;
    if (o_overrun === 1'b1) n_ovr_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_done = 1'b0;
    repeat (gap) tick();
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f, input int gap);
    for (int i = 0; i < 8; i++) send_byte(f[63-8*i -: 8], gap);
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk(o_frame_valid === 1'b0, "consume_drop", 64'(o_frame_valid), 64'd0);
  endtask

  task automatic chk_fields(input string name, input logic [63:0] exp);
    chk(o_frame_valid === 1'b1, {name, "_valid"}, 64'(o_frame_valid), 64'd1);
    chk({o_opcode, o_addr, o_data} === exp, name, {o_opcode, o_addr, o_data}, exp);
  endtask

  initial begin
    int first_to, to0, ovr0;
    logic [63:0] rf;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk({o_frame_valid, o_busy, o_timeout, o_overrun} === 4'b0, "reset_flags",
        64'({o_frame_valid, o_busy, o_timeout, o_overrun}), 64'd0);
    chk({o_opcode, o_addr, o_data} === 64'd0, "reset_fields", {o_opcode, o_addr, o_data}, 64'd0);
    rst_n = 1'b1;

    // Ready while nothing is held has no effect.
    frame_ready = 1'b1;
    repeat (3) tick();
    frame_ready = 1'b0;

    // Single frame at line rate, held until one ready cycle.
    send_frame(64'h0102_A00B_DEADBEEF, BYTE_CYC - 1);
    chk_fields("single", 64'h0102_A00B_DEADBEEF);
    repeat (5) tick();
    chk_fields("single_hold", 64'h0102_A00B_DEADBEEF);
    consume();

    // Timeout after three bytes.
    to0 = n_to_seen;
    send_byte(8'hA1, BYTE_CYC - 1);
    send_byte(8'hA2, BYTE_CYC - 1);
    send_byte(8'hA3, BYTE_CYC - 1);
    first_to = 0;
    for (int k = 1; k <= TO_CYC + 20; k++) begin
      tick();
      if (o_timeout === 1'b1 && first_to == 0) first_to = k;
    end
    chk(first_to == TO_CYC, "timeout_delay", 64'(first_to), 64'(TO_CYC));
    chk(n_to_seen - to0 == 1, "timeout_pulses", 64'(n_to_seen - to0), 64'd1);
    chk(o_busy === 1'b0 && o_frame_valid === 1'b0, "timeout_idle",
        64'({o_busy, o_frame_valid}), 64'd0);

    send_frame(64'h1122_3344_55667788, 3);
    chk_fields("after_timeout", 64'h1122_3344_55667788);
    consume();

    // Late bytes: one gap of TO_CYC-1 cycles and one landing on the expiry edge.
    to0 = n_to_seen;
    send_byte(8'hC0, 2);
    send_byte(8'hC1, 2);
    send_byte(8'hC2, 2);
    send_byte(8'hC3, TO_CYC - 2);
    send_byte(8'hC4, TO_CYC - 1);
    send_byte(8'hC5, 0);
    send_byte(8'hC6, 0);
    send_byte(8'hC7, 0);
    chk(n_to_seen == to0, "race_no_timeout", 64'(n_to_seen - to0), 64'd0);
    chk_fields("race", 64'hC0C1_C2C3_C4C5C6C7);
    consume();

    // Overrun: A held, B completes and is dropped.
    ovr0 = n_ovr_seen;
    send_frame(64'hAAAA_0001_00000011, 2);
    send_frame(64'hBBBB_0002_00000022, 2);
    chk(n_ovr_seen - ovr0 == 1, "overrun_pulses", 64'(n_ovr_seen - ovr0), 64'd1);
    chk_fields("overrun_keeps_a", 64'hAAAA_0001_00000011);

    // C completes in the cycle A is taken: no overrun, C replaces A.
    ovr0 = n_ovr_seen;
    for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), 1);
    rx_data = 8'hEE;
    rx_done = 1'b1;
    frame_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    frame_ready = 1'b0;
    chk(n_ovr_seen == ovr0, "swap_no_overrun", 64'(n_ovr_seen - ovr0), 64'd0);
    chk_fields("swap", 64'hC0C1_C2C3_C4C5C6EE);

    // Reset with C held and five bytes collected.
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1);
    rst_n = 1'b0;
    #1;
    chk({o_frame_valid, o_busy, o_timeout, o_overrun} === 4'b0, "rst_mid_flags",
        64'({o_frame_valid, o_busy, o_timeout, o_overrun}), 64'd0);
    chk({o_opcode, o_addr, o_data} === 64'd0, "rst_mid_fields", {o_opcode, o_addr, o_data}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;
    send_frame(64'h0F1E_2D3C_4B5A6978, 4);
    chk_fields("after_reset", 64'h0F1E_2D3C_4B5A6978);
    consume();

    // Random frames with random spacing up to a byte-time.
    to0  = n_to_seen;
    ovr0 = n_ovr_seen;
    for (int f = 0; f < 3; f++) begin
      rf = {$urandom(), $urandom()};
      for (int i = 0; i < 8; i++) send_byte(rf[63-8*i -: 8], int'($urandom_range(0, BYTE_CYC)));
      chk_fields("random", rf);
      consume();
    end
    chk(n_to_seen == to0 && n_ovr_seen == ovr0, "random_clean",
        64'((n_to_seen - to0) + (n_ovr_seen - ovr0)), 64'd0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
